// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of the program RAM, with bounded burst hold
// and a latency-matched tag pipeline that routes each RAM response back to its requester.
module ram_port_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,

  input  logic        req0_valid_in,
  output logic        req0_ready_out,
  input  logic [31:0] req0_addr_in,
  input  logic [31:0] req0_data_in,
  input  logic [3:0]  req0_we_in,
  output logic        resp0_valid_out,
  output logic [31:0] resp0_data_out,

  input  logic        req1_valid_in,
  output logic        req1_ready_out,
  input  logic [31:0] req1_addr_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req1_we_in,
  output logic        resp1_valid_out,
  output logic [31:0] resp1_data_out,

  output logic [31:0] ram_addr_out,
  output logic [31:0] ram_data_out,
  output logic [3:0]  ram_we_out,
  input  logic [31:0] ram_data_in,

  output logic        busy_out
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic                    lastGrant_q, lastGrant_d;
  logic                    grantedPrev_q, grantedPrev_d;
  logic [3:0]              burstCnt_q, burstCnt_d;
  logic [31:0]             addrHold_q, addrHold_d;
  logic [31:0]             dataHold_q, dataHold_d;
  logic [READ_LATENCY-1:0] pipeValid_q, pipeValid_d;
  logic [READ_LATENCY-1:0] pipePort_q, pipePort_d;

  logic grantValid;
  logic grantPort;
  logic tailValid;
  logic tailPort;

  // The streak owner keeps the port only while it was granted last cycle and is under the cap.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = 1'b0;
    if (!rst_in) begin
      if (req0_valid_in && req1_valid_in) begin
        grantValid = 1'b1;
        if (grantedPrev_q && (burstCnt_q < MAX_CNT)) begin
          grantPort = lastGrant_q;
        end else begin
          grantPort = ~lastGrant_q;
        end
      end else if (req0_valid_in) begin
        grantValid = 1'b1;
        grantPort  = 1'b0;
      end else if (req1_valid_in) begin
        grantValid = 1'b1;
        grantPort  = 1'b1;
      end
    end
  end

  assign req0_ready_out = grantValid && !grantPort;
  assign req1_ready_out = grantValid && grantPort;

  always_comb begin
    ram_addr_out = addrHold_q;
    ram_data_out = dataHold_q;
    ram_we_out   = 4'b0000;
    if (grantValid) begin
      ram_addr_out = grantPort ? req1_addr_in : req0_addr_in;
      ram_data_out = grantPort ? req1_data_in : req0_data_in;
      ram_we_out   = grantPort ? req1_we_in   : req0_we_in;
    end
  end

  always_comb begin
    lastGrant_d   = lastGrant_q;
    burstCnt_d    = burstCnt_q;
    addrHold_d    = addrHold_q;
    dataHold_d    = dataHold_q;
    grantedPrev_d = grantValid;
    if (grantValid) begin
      lastGrant_d = grantPort;
      addrHold_d  = ram_addr_out;
      dataHold_d  = ram_data_out;
      if (grantedPrev_q && (grantPort == lastGrant_q)) begin
        burstCnt_d = (burstCnt_q >= MAX_CNT) ? MAX_CNT : burstCnt_q + 4'd1;
      end else begin
        burstCnt_d = 4'd1;
      end
    end
  end

  // Tag pipeline: slot 0 is loaded on the grant, the last slot lines up with ram_data_in.
  always_comb begin
    pipeValid_d    = '0;
    pipePort_d     = '0;
    pipeValid_d[0] = grantValid;
    pipePort_d[0]  = grantPort;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipeValid_d[i] = pipeValid_q[i-1];
      pipePort_d[i]  = pipePort_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lastGrant_q   <= 1'b1;
      grantedPrev_q <= 1'b0;
      burstCnt_q    <= 4'd0;
      addrHold_q    <= 32'd0;
      dataHold_q    <= 32'd0;
      pipeValid_q   <= '0;
      pipePort_q    <= '0;
    end else begin
      lastGrant_q   <= lastGrant_d;
      grantedPrev_q <= grantedPrev_d;
      burstCnt_q    <= burstCnt_d;
      addrHold_q    <= addrHold_d;
      dataHold_q    <= dataHold_d;
      pipeValid_q   <= pipeValid_d;
      pipePort_q    <= pipePort_d;
    end
  end

  // Outputs are masked during reset so responses already in flight are dropped immediately.
  assign tailValid       = pipeValid_q[READ_LATENCY-1] && !rst_in;
  assign tailPort        = pipePort_q[READ_LATENCY-1];
  assign resp0_valid_out = tailValid && !tailPort;
  assign resp1_valid_out = tailValid && tailPort;
  assign resp0_data_out  = resp0_valid_out ? ram_data_in : 32'd0;
  assign resp1_data_out  = resp1_valid_out ? ram_data_in : 32'd0;
  assign busy_out        = (|pipeValid_q) && !rst_in;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM drives ram_data_in, and a transaction-level
// model (grant rule, response queue, shadow memory) predicts every output each cycle.
module tb_ram_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req0_valid_in, req1_valid_in;
  logic        req0_ready_out, req1_ready_out;
  logic [31:0] req0_addr_in, req0_data_in, req1_addr_in, req1_data_in;
  logic [3:0]  req0_we_in, req1_we_in;
  logic        resp0_valid_out, resp1_valid_out;
  logic [31:0] resp0_data_out, resp1_data_out;
  logic [31:0] ram_addr_out, ram_data_out, ram_data_in;
  logic [3:0]  ram_we_out;
  logic        busy_out;

  ram_port_arbiter #(.READ_LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out),
    .req0_addr_in(req0_addr_in), .req0_data_in(req0_data_in), .req0_we_in(req0_we_in),
    .resp0_valid_out(resp0_valid_out), .resp0_data_out(resp0_data_out),
    .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out),
    .req1_addr_in(req1_addr_in), .req1_data_in(req1_data_in), .req1_we_in(req1_we_in),
    .resp1_valid_out(resp1_valid_out), .resp1_data_out(resp1_data_out),
    .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out), .ram_we_out(ram_we_out),
    .ram_data_in(ram_data_in), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] seedWord(input int i);
    return (i == 64) ? 32'hDEADBEEF : (32'hA5A50000 ^ 32'(i * 257));
  endfunction

  // Behavioural program RAM: read-before-write, data appears LAT cycles after the address.
  logic        loadMem;
  logic [31:0] envMem [256];
  logic [31:0] rdPipe [LAT];

  always @(posedge clk_in) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) envMem[i] <= seedWord(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we_out[b]) envMem[ram_addr_out[9:2]][8*b +: 8] <= ram_data_out[8*b +: 8];
    end
    rdPipe[0] <= envMem[ram_addr_out[9:2]];
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign ram_data_in = rdPipe[LAT-1];

  typedef struct {
    int          due;
    bit          port;
    bit          isRead;
    logic [31:0] data;
  } resp_t;

  resp_t       expQ[$];
  logic [31:0] refMem [256];
  int          lastGrant = 1;
  int          streak = 0;
  bit          grantedLast = 1'b0;
  logic [31:0] lastAddr = 32'd0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic randReq();
    req0_addr_in = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    req1_addr_in = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    req0_data_in = $urandom;
    req1_data_in = $urandom;
    req0_we_in   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    req1_we_in   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
  endtask

  // Checks one cycle against the model, then advances the model across the clock edge.
  task automatic checkOutput();
    bit          gv = 1'b0;
    int          gp = 0;
    logic [31:0] eAddr, eData;
    logic [3:0]  eWe;
    bit          r0v = 1'b0, r1v = 1'b0, rRead = 1'b0;
    logic [31:0] rData = 32'd0;
    int          idx;
    #3;
    if (rst_in) begin
      check("rst_ready0", 32'(req0_ready_out), 32'd0);
      check("rst_ready1", 32'(req1_ready_out), 32'd0);
      check("rst_we", 32'(ram_we_out), 32'd0);
      check("rst_resp0", 32'(resp0_valid_out), 32'd0);
      check("rst_resp1", 32'(resp1_valid_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
    end else begin
      if (req0_valid_in && req1_valid_in) begin
        gv = 1'b1;
        gp = (grantedLast && streak < MAXB) ? lastGrant : 1 - lastGrant;
      end else if (req0_valid_in || req1_valid_in) begin
        gv = 1'b1;
        gp = req1_valid_in ? 1 : 0;
      end
      eAddr = gv ? (gp == 1 ? req1_addr_in : req0_addr_in) : lastAddr;
      eData = gp == 1 ? req1_data_in : req0_data_in;
      eWe   = gv ? (gp == 1 ? req1_we_in : req0_we_in) : 4'b0000;
      if (expQ.size() > 0 && expQ[0].due == cycle) begin
        r0v   = !expQ[0].port;
        r1v   = expQ[0].port;
        rRead = expQ[0].isRead;
        rData = expQ[0].data;
      end
      check("ready0", 32'(req0_ready_out), 32'(gv && gp == 0));
      check("ready1", 32'(req1_ready_out), 32'(gv && gp == 1));
      check("ram_addr", ram_addr_out, eAddr);
      check("ram_we", 32'(ram_we_out), 32'(eWe));
      if (gv) check("ram_data", ram_data_out, eData);
      check("busy", 32'(busy_out), 32'(expQ.size() != 0));
      check("resp0_valid", 32'(resp0_valid_out), 32'(r0v));
      check("resp1_valid", 32'(resp1_valid_out), 32'(r1v));
      if (r0v && rRead) check("resp0_data", resp0_data_out, rData);
      if (r1v && rRead) check("resp1_data", resp1_data_out, rData);
      if (!r0v) check("resp0_data_zero", resp0_data_out, 32'd0);
      if (!r1v) check("resp1_data_zero", resp1_data_out, 32'd0);
    end
    @(posedge clk_in);
    #1;
    if (rst_in) begin
      lastGrant = 1; streak = 0; grantedLast = 1'b0; lastAddr = 32'd0;
      expQ.delete();
    end else begin
      if (expQ.size() > 0 && expQ[0].due == cycle) void'(expQ.pop_front());
      if (gv) begin
        streak = (grantedLast && gp == lastGrant) ? ((streak + 1 > MAXB) ? MAXB : streak + 1) : 1;
        lastGrant = gp;
        lastAddr  = eAddr;
        idx = int'(eAddr[9:2]);
        expQ.push_back('{due: cycle + LAT, port: (gp == 1), isRead: (eWe == 4'b0000), data: refMem[idx]});
        for (int b = 0; b < 4; b++) if (eWe[b]) refMem[idx][8*b +: 8] = eData[8*b +: 8];
      end
      grantedLast = gv;
    end
    cycle++;
  endtask

  task automatic applyStimulus(input bit r, input bit va, input bit vb);
    rst_in        = r;
    req0_valid_in = va;
    req1_valid_in = vb;
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
    loadMem = 1'b1;
    randReq();
    applyStimulus(1, 0, 0);
    loadMem = 1'b0;
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);

    // Port 0 reads the preloaded word at 0x100.
    req0_addr_in = 32'h100; req0_we_in = 4'b0000;
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0);

    // Both ports contend continuously.
    for (int i = 0; i < 12; i++) begin
      randReq();
      applyStimulus(0, 1, 1);
    end
    repeat (3) applyStimulus(0, 0, 0);

    // Port 0 streams, port 1 joins two cycles later.
    for (int i = 0; i < 10; i++) begin
      randReq();
      applyStimulus(0, i < 8, i >= 2 && i < 6);
    end
    repeat (3) applyStimulus(0, 0, 0);

    // Port 1 partial write at 0x40, then read it back.
    req1_addr_in = 32'h40; req1_data_in = 32'h12345678; req1_we_in = 4'b0011;
    applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0);
    req1_we_in = 4'b0000;
    applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0);

    // Reset right after an accepted read drops its response.
    randReq(); req0_we_in = 4'b0000;
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    repeat (5) applyStimulus(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      randReq();
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (4) applyStimulus(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
